// File: rtl/score_keeper_if.sv
// Player-event and game-status bundle between the input decoder / VGA side
// and the score_keeper engine.
interface score_keeper_if;
  logic        btn_start;
  logic        hit_valid;
  logic        hit_correct;
  logic        tick;
  logic        ingame;
  logic [31:0] score;
  logic [3:0]  lives;
  logic [15:0] time_left;
  logic        game_won;
  logic        game_lost;

  modport slave (
    input  btn_start, hit_valid, hit_correct, tick,
    output ingame, score, lives, time_left, game_won, game_lost
  );

  modport master (
    output btn_start, hit_valid, hit_correct, tick,
    input  ingame, score, lives, time_left, game_won, game_lost
  );
endinterface

// File: rtl/score_keeper.sv
// Round state machine with saturating score, life counter and countdown timer.
// Feeds the ingame/score view of the VGA tile-reveal display.
module score_keeper #(
  parameter int unsigned MAX_SCORE   = 12,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned ROUND_TICKS = 600
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE} state_e;

  localparam logic [31:0] SCORE_MAX  = 32'(MAX_SCORE);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
  localparam logic [15:0] TICKS_INIT = 16'(ROUND_TICKS);

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        btn_prev_q, btn_prev_d;
  logic        start_p_q, start_p_d;
  logic [31:0] score_q, score_d;
  logic [3:0]  lives_q, lives_d;
  logic [15:0] time_left_q, time_left_d;

  logic hit, miss;
  assign hit  = bus.hit_valid &  bus.hit_correct;
  assign miss = bus.hit_valid & ~bus.hit_correct;

  // Button synchroniser plus registered rising-edge detect: one pulse per press.
  always_comb begin
    sync1_d    = bus.btn_start;
    sync2_d    = sync1_q;
    btn_prev_d = sync2_q;
    start_p_d  = sync2_q & ~btn_prev_q;
  end

  // Counter datapath. Events only count in PLAY; a start pulse outside PLAY
  // reloads the round and swallows any same-cycle hit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    score_d     = score_q;
    lives_d     = lives_q;
    time_left_d = time_left_q;
    if (state_q == S_PLAY) begin
      if (hit && (score_q < SCORE_MAX))    score_d     = score_q + 32'd1;
      if (miss && (lives_q != 4'd0))       lives_d     = lives_q - 4'd1;
      if (bus.tick && (time_left_q != '0)) time_left_d = time_left_q - 16'd1;
    end else if (start_p_q) begin
      score_d     = '0;
      lives_d     = LIVES_INIT;
      time_left_d = TICKS_INIT;
    end
  end

  // Next-state: a winning hit beats a simultaneous miss or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PLAY: begin
        if (score_d == SCORE_MAX)                            state_d = S_WIN;
        else if ((lives_d == 4'd0) || (time_left_d == '0))   state_d = S_LOSE;
      end
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_p_q) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_prev_q  <= 1'b0;
      start_p_q   <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      time_left_q <= TICKS_INIT;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_prev_q  <= btn_prev_d;
      start_p_q   <= start_p_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      time_left_q <= time_left_d;
    end
  end

  // Status flags are pure decodes of the registered state.
  always_comb begin
    bus.ingame    = (state_q == S_PLAY);
    bus.game_won  = (state_q == S_WIN);
    bus.game_lost = (state_q == S_LOSE);
    bus.score     = score_q;
    bus.lives     = lives_q;
    bus.time_left = time_left_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (600-tick and 5-tick rounds) driven in
// lockstep, compared every cycle against a round-level reference model.
module tb_score_keeper;

  localparam int MAXS   = 12;
  localparam int NLIVES = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  score_keeper_if bus_a ();
  score_keeper_if bus_b ();

  score_keeper #(.MAX_SCORE(MAXS), .LIVES(NLIVES), .ROUND_TICKS(600)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a));
  score_keeper #(.MAX_SCORE(MAXS), .LIVES(NLIVES), .ROUND_TICKS(5)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b));

  int ticks_cfg [2] = '{600, 5};
  int m_score   [2];
  int m_lives   [2];
  int m_time    [2];
  bit m_play    [2];
  bit m_won     [2];
  bit m_lost    [2];
  bit btn_hist  [5];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0;
      m_lives[i] = NLIVES;
      m_time[i]  = ticks_cfg[i];
      m_play[i]  = 1'b0;
      m_won[i]   = 1'b0;
      m_lost[i]  = 1'b0;
    end
    for (int k = 0; k < 5; k++) btn_hist[k] = 1'b0;
  endtask

  // One clock edge of the game rules. A button level seen at edge k yields a
  // round start at edge k+3 if it was low the edge before.
  task automatic model_edge(input bit hv, input bit hc, input bit tk, input bit bt);
    bit start;
    for (int k = 4; k > 0; k--) btn_hist[k] = btn_hist[k-1];
    btn_hist[0] = bt;
    start = btn_hist[3] && !btn_hist[4];
    for (int i = 0; i < 2; i++) begin
      if (!m_play[i]) begin
        if (start) begin
          m_play[i] = 1'b1; m_won[i] = 1'b0; m_lost[i] = 1'b0;
          m_score[i] = 0; m_lives[i] = NLIVES; m_time[i] = ticks_cfg[i];
        end
      end else begin
        if (hv && hc && m_score[i] < MAXS) m_score[i]++;
        if (hv && !hc && m_lives[i] > 0)   m_lives[i]--;
        if (tk && m_time[i] > 0)           m_time[i]--;
        if (m_score[i] == MAXS) begin
          m_play[i] = 1'b0; m_won[i] = 1'b1;
        end else if (m_lives[i] == 0 || m_time[i] == 0) begin
          m_play[i] = 1'b0; m_lost[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_dut(input string where, input int i, input logic [31:0] sc,
                           input logic [3:0] lv, input logic [15:0] tl,
                           input logic ig, input logic w, input logic l);
    check($sformatf("%s[%0d].score", where, i),     sc,          32'(m_score[i]));
    check($sformatf("%s[%0d].lives", where, i),     32'(lv),     32'(m_lives[i]));
    check($sformatf("%s[%0d].time_left", where, i), 32'(tl),     32'(m_time[i]));
    check($sformatf("%s[%0d].ingame", where, i),    32'(ig),     32'(m_play[i]));
    check($sformatf("%s[%0d].game_won", where, i),  32'(w),      32'(m_won[i]));
    check($sformatf("%s[%0d].game_lost", where, i), 32'(l),      32'(m_lost[i]));
  endtask

  task automatic check_all(input string where);
    check_dut(where, 0, bus_a.score, bus_a.lives, bus_a.time_left,
              bus_a.ingame, bus_a.game_won, bus_a.game_lost);
    check_dut(where, 1, bus_b.score, bus_b.lives, bus_b.time_left,
              bus_b.ingame, bus_b.game_won, bus_b.game_lost);
  endtask

  task automatic drive(input bit hv, input bit hc, input bit tk, input bit bt);
    bus_a.hit_valid = hv; bus_a.hit_correct = hc; bus_a.tick = tk; bus_a.btn_start = bt;
    bus_b.hit_valid = hv; bus_b.hit_correct = hc; bus_b.tick = tk; bus_b.btn_start = bt;
  endtask

  // Called 1 time unit after an edge; applies inputs for the next edge and checks after it.
  task automatic step(input string where, input bit hv, input bit hc, input bit tk, input bit bt);
    drive(hv, hc, tk, bt);
    @(posedge clk);
    model_edge(hv, hc, tk, bt);
    #1;
    check_all(where);
  endtask

  task automatic press(input string where);
    repeat (2) step(where, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) step(where, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit bt;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Held button: exactly one start, no restart while held.
    repeat (100) step("start_held", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3)   step("start_rel", 1'b0, 1'b0, 1'b0, 1'b0);

    // 12 back-to-back hits win, extra hits leave score saturated.
    repeat (12) step("hits", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3)  step("post_win", 1'b1, 1'b1, 1'b1, 1'b0);

    // Hit/miss interleave down to zero lives.
    press("restart1");
    step("hm", 1'b1, 1'b1, 1'b0, 1'b0);
    step("hm", 1'b1, 1'b0, 1'b0, 1'b0);
    step("hm", 1'b1, 1'b1, 1'b0, 1'b0);
    step("hm", 1'b1, 1'b0, 1'b0, 1'b0);
    step("hm", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step("post_lose", 1'b1, 1'b1, 1'b1, 1'b0);

    // Timeout on the short-round instance.
    press("restart2");
    repeat (5) step("ticks", 1'b0, 1'b0, 1'b1, 1'b0);
    step("post_timeout", 1'b0, 1'b0, 1'b1, 1'b0);

    // Final hit coinciding with the final tick wins.
    press("restart3");
    repeat (4)  step("pre_ticks", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (11) step("hits11", 1'b1, 1'b1, 1'b0, 1'b0);
    step("hit_on_last_tick", 1'b1, 1'b1, 1'b1, 1'b0);
    step("after_last_tick", 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-round at score 7, between clock edges.
    press("restart4");
    repeat (7) step("hits7", 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    press("restart_after_reset");
    step("fresh", 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized play against the reference model.
    bt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit hv, hc, tk;
      hv = ($urandom_range(0, 2) == 0);
      hc = ($urandom_range(0, 3) != 0);
      tk = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) bt = ~bt;
      step("random", hv, hc, tk, bt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
